// File: rtl/bpu_track_fifo.sv
// bpu_track_fifo: in-order branch tracking queue between gshare lookup and branch resolution, with mispredict flush.
// Optional BPU_TRACK_STATS_EN adds saturating resolved-branch and mispredict counters.
module bpu_track_fifo #(
  parameter int GSHARE_BITS_NUM = 5,
  parameter int OPTION_OPERAND_WIDTH = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Branch_F,
  input  logic [GSHARE_BITS_NUM-1:0]      push_idx,
  input  logic                            push_pred,
  input  logic [OPTION_OPERAND_WIDTH-1:0] push_pc,
  input  logic                            Branch_EX,
  input  logic                            taken,
  output logic [GSHARE_BITS_NUM-1:0]      prev_idx,
  output logic [OPTION_OPERAND_WIDTH-1:0] head_pc,
  output logic                            mispredict,
  output logic                            pop_valid,
  output logic                            full,
  output logic                            empty,
  output logic [DEPTH_LOG2:0]             count,
  output logic                            overflow,
  output logic                            underflow
`ifdef BPU_TRACK_STATS_EN
  ,
  output logic [15:0]                     stat_branches,
  output logic [15:0]                     stat_mispredicts
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [GSHARE_BITS_NUM-1:0]      mem_idx [DEPTH];
  logic                            mem_pred [DEPTH];
  logic [OPTION_OPERAND_WIDTH-1:0] mem_pc [DEPTH];
  logic [DEPTH_LOG2-1:0]           rd, wr;
  logic                            push_ok;
  assign empty      = count == '0;
  assign full       = count == CW'(DEPTH);
  assign pop_valid  = Branch_EX & ~empty;
  assign mispredict = pop_valid & (mem_pred[rd] != taken);
  assign prev_idx   = empty ? '0 : mem_idx[rd];
  assign head_pc    = empty ? '0 : mem_pc[rd];
  // a push alongside a mispredict is wrong-path; at full it only fits behind a pop
  assign push_ok    = Branch_F & ~mispredict & (~full | pop_valid);
  always_ff @(posedge clk)
    if (push_ok) begin
      mem_idx[wr]  <= push_idx;
      mem_pred[wr] <= push_pred;
      mem_pc[wr]   <= push_pc;
    end
  always_ff @(posedge clk)
    if (rst) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd        <= mispredict ? wr : rd + DEPTH_LOG2'(pop_valid);
      wr        <= wr + DEPTH_LOG2'(push_ok);
      count     <= mispredict ? '0 : count + CW'(push_ok) - CW'(pop_valid);
      overflow  <= overflow | (Branch_F & full & ~pop_valid);
      underflow <= underflow | (Branch_EX & empty);
    end
`ifdef BPU_TRACK_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_branches    <= stat_branches + 16'(pop_valid & (stat_branches != 16'hFFFF));
      stat_mispredicts <= stat_mispredicts + 16'(mispredict & (stat_mispredicts != 16'hFFFF));
    end
`endif
endmodule

// File: doc/bpu_track_fifo.md
# bpu_track_fifo

Branch-tracking queue between the fetch-stage gshare lookup and the execute-stage branch resolution. Every predicted branch pushes its pattern-table index, predicted direction and PC at fetch. On resolution, the queue hands the oldest entry back to the predictor as `prev_idx` and raises `mispredict` when the outcome differs from the stored prediction. On a mispredict it flushes all younger (wrong-path) entries so the predictor only ever trains on committed-path branches.

## Interface
Parameters:
- `GSHARE_BITS_NUM`, 5, width of the pattern-table index; must match the predictor.
- `OPTION_OPERAND_WIDTH`, 10, width of the stored branch PC.
- `DEPTH_LOG2`, 2, log2 of the queue depth (default depth 4 entries).

Ports:
- `clk` input 1: single clock, all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Branch_F` input 1: push request; a branch was predicted in fetch this cycle.
- `push_idx` input GSHARE_BITS_NUM: predictor `state_index` for the pushed branch.
- `push_pred` input 1: predicted direction, 1 = taken.
- `push_pc` input OPTION_OPERAND_WIDTH: branch PC.
- `Branch_EX` input 1: pop request; the oldest branch resolves this cycle.
- `taken` input 1: actual outcome of the resolving branch.
- `prev_idx` output GSHARE_BITS_NUM: head entry index; 0 when empty.
- `head_pc` output OPTION_OPERAND_WIDTH: head entry PC; 0 when empty.
- `mispredict` output 1: `Branch_EX & !empty & (head_pred != taken)`.
- `pop_valid` output 1: `Branch_EX & !empty`; the predictor must gate training with this signal.
- `full`, `empty` output 1: occupancy flags.
- `count` output DEPTH_LOG2+1: number of valid entries.
- `overflow`, `underflow` output 1: sticky error flags, cleared only by `rst`.

## Operation
- Circular buffer with `DEPTH_LOG2`-bit read and write pointers; pointers wrap modulo depth; `count` is tracked explicitly.
- Push: if `Branch_F` and not full (or full with a simultaneous non-mispredict pop), store `{push_idx, push_pred, push_pc}` at the write pointer and advance it.
- Push when full without a pop: the entry is dropped and `overflow` is set.
- Pop: if `pop_valid`, advance the read pointer. `Branch_EX` while empty is ignored and sets `underflow`. Outputs stay 0 in that case.
- Simultaneous push and pop, no mispredict: both occur and `count` is unchanged. This is legal at full and at empty+1.
- Mispredict: read pointer ← write pointer and `count` ← 0. All younger entries are discarded. A push in the same cycle is wrong-path and is dropped without setting `overflow`.
- `rst`: pointers, `count`, sticky flags and statistics are cleared to 0. Entry storage need not be cleared. Mid-operation reset discards all entries the same cycle.
- Reset output values: `empty`=1, `full`=0, `count`=0, `prev_idx`=0, `head_pc`=0, `mispredict`=0, `pop_valid`=0, `overflow`=0, `underflow`=0.

## Timing
- `prev_idx`, `head_pc`, `mispredict` and `pop_valid` are combinational from head registers and current inputs. They are valid in the same cycle as `Branch_EX`, with zero latency.
- An entry pushed in cycle N is visible at the head no earlier than cycle N+1. Fall-through from push to pop in one cycle is not supported.
- `full`, `empty` and `count` are registered and reflect all pushes and pops of the previous edge.
- After a mispredict in cycle N, `empty`=1 in cycle N+1.

## Configuration
- `BPU_TRACK_STATS_EN` defined: adds outputs `stat_branches` and `stat_mispredicts`, each 16 bits.
  - `stat_branches` increments on every `pop_valid`.
  - `stat_mispredicts` increments on every `mispredict`.
  - Both saturate at 16'hFFFF and clear on `rst`.
- `BPU_TRACK_STATS_EN` not defined: those ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then push idx 3/pred 1, 7/pred 0, 12/pred 1 on three cycles → `count`=3. Pop with `taken`=1 → `prev_idx`=3, `mispredict`=0, `count`=2.
- Fill 4 entries, push a 5th (idx 9) with no pop → `overflow`=1, `count`=4, entry 9 is never popped.
- Head idx 5/pred 1. Pop with `taken`=0 while 2 younger entries are queued and `Branch_F`=1 → `mispredict`=1, `prev_idx`=5, next cycle `empty`=1, `count`=0, `overflow`=0.
- Pop on empty queue → `pop_valid`=0, `mispredict`=0, `prev_idx`=0, `underflow`=1 and stays 1 until `rst`.
- At full, push and correct-predict pop in the same cycle, repeated for 10 cycles → `count` stays 4, pointers wrap, and pops return the pushed indices in order.
- With `BPU_TRACK_STATS_EN`: 6 pops including 2 mispredicts → `stat_branches`=6, `stat_mispredicts`=2. Assert `rst` mid-stream → counters and `count` read 0 the next cycle.
